hsl_convert_sched: RTL and testbench

//  Shares one combinational rgb2hsl converter between two pixel requesters (A, B).
//   - A: video-scan path. B: sample/probe path.

---
 rtl/hsl_convert_sched.sv | 201 ++++++++++++++++++++
 tb/tb_hsl_convert_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsl_convert_sched.sv
// Shares one combinational rgb2hsl converter between requesters A (video scan) and B (probe).
// Latency: handshake at edge N -> registered result on out_* after edge N+1; 1 pixel/clk sustained.
// Backpressure: out_ready low holds S2, S1 holds if occupied, and a_ready/b_ready drop accordingly.
module hsl_convert_sched #(
  parameter int ARB_MODE = 0,   // 0 = round-robin, 1 = A always wins
  parameter int CNT_W    = 16   // width of the saturating accepted-pixel counters
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [23:0]      a_rgb,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [23:0]      b_rgb,
  output logic             b_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [8:0]       out_hue,
  output logic [17:0]      out_sat,
  output logic [17:0]      out_lum,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Stage S1: arbitrated pixel waiting for the converter
  logic        r_v1;
  logic        r_id1;
  logic [23:0] r_rgb1;

  // Stage S2: converted result presented on the output stream
  logic        r_v2;
  logic        r_id2;
  logic [8:0]  r_hue;
  logic [17:0] r_sat;
  logic [17:0] r_lum;

  // Round-robin history: 1 means B won last, so A wins the next contested cycle
  logic        r_last_id;

  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  // Pipeline advance and arbitration wires
  logic        w_ld1;
  logic        w_ld2;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_grant_any;
  logic        w_gid;
  logic [23:0] w_grant_rgb;

  // Converter wires
  logic [7:0]         w_r;
  logic [7:0]         w_g;
  logic [7:0]         w_b;
  logic [7:0]         w_max;
  logic [7:0]         w_min;
  logic [7:0]         w_d;
  logic [8:0]         w_sum;
  logic [8:0]         w_den9;
  logic [7:0]         w_den;
  logic [8:0]         w_base;
  logic signed [15:0] w_diff;
  logic signed [15:0] w_num;
  logic signed [15:0] w_hq;
  logic signed [15:0] w_h;
  logic [8:0]         w_hue;
  logic [17:0]        w_sat;
  logic [17:0]        w_lum;

  // S2 can take new data when empty or being drained; S1 can when empty or moving on
  assign w_ld2 = !r_v2 | out_ready;
  assign w_ld1 = !r_v1 | w_ld2;

  // Grant only while S1 can load, so a ready never asserts into a stalled stage
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (w_ld1) begin
      if (a_valid && b_valid) begin
        if (ARB_MODE == 1) begin
          w_grant_a = 1'b1;
        end else if (r_last_id) begin
          w_grant_a = 1'b1;
        end else begin
          w_grant_b = 1'b1;
        end
      end else begin
        w_grant_a = a_valid;
        w_grant_b = b_valid;
      end
    end
  end

  assign w_grant_any = w_grant_a | w_grant_b;
  assign w_gid       = w_grant_b;
  assign w_grant_rgb = w_grant_b ? b_rgb : a_rgb;

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  // rgb2hsl on the S1 pixel: integer hue in degrees, sat/lum in 2.16 fixed point
  always_comb begin
    w_r    = r_rgb1[23:16];
    w_g    = r_rgb1[15:8];
    w_b    = r_rgb1[7:0];
    w_max  = w_r;
    w_min  = w_r;
    if (w_g > w_max) w_max = w_g;
    if (w_b > w_max) w_max = w_b;
    if (w_g < w_min) w_min = w_g;
    if (w_b < w_min) w_min = w_b;
    w_d    = w_max - w_min;
    w_sum  = {1'b0, w_max} + {1'b0, w_min};
    w_den9 = 9'd510 - w_sum;
    // Saturation denominator is max+min for the dark half, 510-(max+min) for the light half
    w_den  = (w_sum <= 9'd255) ? w_sum[7:0] : w_den9[7:0];
    w_base = 9'd0;
    w_diff = 16'sd0;
    w_num  = 16'sd0;
    w_hq   = 16'sd0;
    w_h    = 16'sd0;
    w_hue  = 9'd0;
    w_sat  = 18'd0;
    w_lum  = 18'({w_sum, 15'd0} / 24'd255);
    // Grey pixels (including black) have no chroma, so hue and sat stay zero
    if (w_d != 8'd0) begin
      if (w_r == w_max) begin
        w_base = 9'd0;
        w_diff = $signed({8'd0, w_g}) - $signed({8'd0, w_b});
      end else if (w_g == w_max) begin
        w_base = 9'd120;
        w_diff = $signed({8'd0, w_b}) - $signed({8'd0, w_r});
      end else begin
        w_base = 9'd240;
        w_diff = $signed({8'd0, w_r}) - $signed({8'd0, w_g});
      end
      w_num = w_diff * 16'sd60;
      // Signed division truncates toward zero; negative angles wrap into 0..359
      w_hq  = w_num / $signed({8'd0, w_d});
      w_h   = $signed({7'd0, w_base}) + w_hq;
      if (w_h < 16'sd0) w_h = w_h + 16'sd360;
      w_hue = 9'(w_h);
      // w_d never exceeds the denominator, so sat tops out at exactly 1.0
      w_sat = 18'({w_d, 16'd0} / {16'd0, w_den});
    end
  end

  // Pipeline registers, round-robin history and saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_id1     <= 1'b0;
      r_rgb1    <= 24'd0;
      r_v2      <= 1'b0;
      r_id2     <= 1'b0;
      r_hue     <= 9'd0;
      r_sat     <= 18'd0;
      r_lum     <= 18'd0;
      r_last_id <= 1'b1;
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
    end else begin
      if (w_ld2) begin
        r_v2  <= r_v1;
        r_id2 <= r_id1;
        r_hue <= w_hue;
        r_sat <= w_sat;
        r_lum <= w_lum;
      end
      if (w_ld1) begin
        r_v1   <= w_grant_any;
        r_id1  <= w_gid;
        r_rgb1 <= w_grant_rgb;
      end
      if (w_grant_any) begin
        r_last_id <= w_gid;
      end
      if (a_valid && a_ready && (r_cnt_a != '1)) begin
        r_cnt_a <= r_cnt_a + CNT_ONE;
      end
      if (b_valid && b_ready && (r_cnt_b != '1)) begin
        r_cnt_b <= r_cnt_b + CNT_ONE;
      end
    end
  end

  assign out_valid = r_v2;
  assign out_id    = r_id2;
  assign out_hue   = r_hue;
  assign out_sat   = r_sat;
  assign out_lum   = r_lum;
  assign busy      = r_v1 | r_v2;
  assign cnt_a     = r_cnt_a;
  assign cnt_b     = r_cnt_b;

endmodule

// File: tb/tb_hsl_convert_sched.sv
// Directed bench for hsl_convert_sched: conversion table, arbitration, stall, bubble, reset, saturation.
// Three instances share stimulus: round-robin (CNT_W=16), fixed priority, and a CNT_W=4 build.
// Inputs change 1 time unit after the rising edge; outputs are sampled in that same quiet window.
module tb_hsl_convert_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, out_ready;
  logic [23:0] a_rgb, b_rgb;

  // round-robin instance
  logic        rr_a_ready, rr_b_ready, rr_out_valid, rr_out_id, rr_busy;
  logic [8:0]  rr_hue;
  logic [17:0] rr_sat, rr_lum;
  logic [15:0] rr_cnt_a, rr_cnt_b;
  // fixed-priority instance
  logic        fp_a_ready, fp_b_ready, fp_out_valid, fp_out_id, fp_busy;
  logic [8:0]  fp_hue;
  logic [17:0] fp_sat, fp_lum;
  logic [15:0] fp_cnt_a, fp_cnt_b;
  // 4-bit counter instance
  logic        c4_a_ready, c4_b_ready, c4_out_valid, c4_out_id, c4_busy;
  logic [8:0]  c4_hue;
  logic [17:0] c4_sat, c4_lum;
  logic [3:0]  c4_cnt_a, c4_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hsl_convert_sched #(.ARB_MODE(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rgb(a_rgb), .a_ready(rr_a_ready),
    .b_valid(b_valid), .b_rgb(b_rgb), .b_ready(rr_b_ready),
    .out_valid(rr_out_valid), .out_ready(out_ready), .out_id(rr_out_id),
    .out_hue(rr_hue), .out_sat(rr_sat), .out_lum(rr_lum),
    .busy(rr_busy), .cnt_a(rr_cnt_a), .cnt_b(rr_cnt_b)
  );

  hsl_convert_sched #(.ARB_MODE(1), .CNT_W(16)) dut_fp (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rgb(a_rgb), .a_ready(fp_a_ready),
    .b_valid(b_valid), .b_rgb(b_rgb), .b_ready(fp_b_ready),
    .out_valid(fp_out_valid), .out_ready(out_ready), .out_id(fp_out_id),
    .out_hue(fp_hue), .out_sat(fp_sat), .out_lum(fp_lum),
    .busy(fp_busy), .cnt_a(fp_cnt_a), .cnt_b(fp_cnt_b)
  );

  hsl_convert_sched #(.ARB_MODE(0), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rgb(a_rgb), .a_ready(c4_a_ready),
    .b_valid(b_valid), .b_rgb(b_rgb), .b_ready(c4_b_ready),
    .out_valid(c4_out_valid), .out_ready(out_ready), .out_id(c4_out_id),
    .out_hue(c4_hue), .out_sat(c4_sat), .out_lum(c4_lum),
    .busy(c4_busy), .cnt_a(c4_cnt_a), .cnt_b(c4_cnt_b)
  );

  typedef struct {
    logic [23:0] rgb;
    logic [8:0]  hue;
    logic [17:0] sat;
    logic [17:0] lum;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    out_ready = 1'b1;
    a_rgb     = 24'd0;
    b_rgb     = 24'd0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // rgb, hue, sat (2.16), lum (2.16)
    vecs[0] = '{24'hFF0000,   9'd0, 18'h10000, 18'h08000};
    vecs[1] = '{24'h00FF00, 9'd120, 18'h10000, 18'h08000};
    vecs[2] = '{24'h0000FF, 9'd240, 18'h10000, 18'h08000};
    vecs[3] = '{24'hFFFFFF,   9'd0, 18'h00000, 18'h10000};
    vecs[4] = '{24'h000000,   9'd0, 18'h00000, 18'h00000};
    vecs[5] = '{24'h808080,   9'd0, 18'h00000, 18'h08080};
    vecs[6] = '{24'hFF8000,  9'd30, 18'h10000, 18'h08000};
    vecs[7] = '{24'hFF0080, 9'd330, 18'h10000, 18'h08000};
    vecs[8] = '{24'h804040,   9'd0, 18'h05555, 18'h06060};
    vecs[9] = '{24'hC08080,   9'd0, 18'h0563B, 18'h0A0A0};

    do_reset();

    // reset state
    chk("rst_out_valid", rr_out_valid, 0);
    chk("rst_busy", rr_busy, 0);
    chk("rst_out_id", rr_out_id, 0);
    chk("rst_hue", rr_hue, 0);
    chk("rst_sat", rr_sat, 0);
    chk("rst_lum", rr_lum, 0);
    chk("rst_cnt_a", rr_cnt_a, 0);
    chk("rst_cnt_b", rr_cnt_b, 0);

    // conversion table: one A pixel at a time, 2-cycle latency
    for (int i = 0; i < 10; i++) begin
      a_valid = 1'b1;
      a_rgb   = vecs[i].rgb;
      #1;
      chk($sformatf("v%0d_a_ready", i), rr_a_ready, 1);
      step();
      a_valid = 1'b0;
      chk($sformatf("v%0d_cnt_a", i), rr_cnt_a, 32'(i + 1));
      chk($sformatf("v%0d_early_valid", i), rr_out_valid, 0);
      step();
      chk($sformatf("v%0d_out_valid", i), rr_out_valid, 1);
      chk($sformatf("v%0d_out_id", i), rr_out_id, 0);
      chk($sformatf("v%0d_hue", i), rr_hue, vecs[i].hue);
      chk($sformatf("v%0d_sat", i), rr_sat, vecs[i].sat);
      chk($sformatf("v%0d_lum", i), rr_lum, vecs[i].lum);
      step();
      chk($sformatf("v%0d_drained", i), rr_out_valid, 0);
    end

    // both requesters every cycle: A=red, B=blue
    do_reset();
    a_valid = 1'b1; a_rgb = 24'hFF0000;
    b_valid = 1'b1; b_rgb = 24'h0000FF;
    #1;
    chk("rr_first_a_ready", rr_a_ready, 1);
    chk("rr_first_b_ready", rr_b_ready, 0);
    step();
    step();
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("rr%0d_valid", k), rr_out_valid, 1);
      chk($sformatf("rr%0d_id", k), rr_out_id, 32'(k % 2));
      chk($sformatf("rr%0d_hue", k), rr_hue, (k % 2 == 1) ? 32'd240 : 32'd0);
      chk($sformatf("fp%0d_id", k), fp_out_id, 0);
      chk($sformatf("fp%0d_b_ready", k), fp_b_ready, 0);
      step();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    // 9 handshakes: A,B,A,B,A,B,A,B,A
    chk("rr_cnt_a", rr_cnt_a, 5);
    chk("rr_cnt_b", rr_cnt_b, 4);
    chk("fp_cnt_a", fp_cnt_a, 9);
    chk("fp_cnt_b", fp_cnt_b, 0);

    // reset with both stages full; last winner was A, so only reset makes A win next
    chk("inflight_busy", rr_busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_rst_valid", rr_out_valid, 0);
    chk("post_rst_busy", rr_busy, 0);
    chk("post_rst_cnt_a", rr_cnt_a, 0);
    chk("post_rst_cnt_b", rr_cnt_b, 0);
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("post_rst_a_ready", rr_a_ready, 1);
    chk("post_rst_b_ready", rr_b_ready, 0);
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    chk("post_rst_out_id", rr_out_id, 0);
    chk("post_rst_out_hue", rr_hue, 0);

    // stall: green then blue, consumer stalls 5 cycles after the first result
    do_reset();
    a_valid = 1'b1; a_rgb = 24'h00FF00;
    step();
    a_rgb = 24'h0000FF;
    step();
    chk("stall_first_valid", rr_out_valid, 1);
    chk("stall_first_hue", rr_hue, 120);
    out_ready = 1'b0;
    a_rgb = 24'hFF0000;
    #1;
    chk("stall_a_ready0", rr_a_ready, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d_valid", k), rr_out_valid, 1);
      chk($sformatf("stall%0d_hue", k), rr_hue, 120);
      chk($sformatf("stall%0d_a_ready", k), rr_a_ready, 0);
      chk($sformatf("stall%0d_busy", k), rr_busy, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_a_ready", rr_a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("release_blue_valid", rr_out_valid, 1);
    chk("release_blue_hue", rr_hue, 240);
    step();
    chk("release_red_valid", rr_out_valid, 1);
    chk("release_red_hue", rr_hue, 0);
    chk("release_red_sat", rr_sat, 18'h10000);
    step();
    chk("release_empty", rr_out_valid, 0);
    chk("release_cnt_a", rr_cnt_a, 3);

    // bubble collapse: S2 stalled, S1 empty -> S1 still accepts one pixel
    do_reset();
    out_ready = 1'b0;
    a_valid = 1'b1; a_rgb = 24'h00FF00;
    step();
    a_valid = 1'b0;
    step();
    chk("bubble_v2", rr_out_valid, 1);
    a_valid = 1'b1; a_rgb = 24'h0000FF;
    #1;
    chk("bubble_accept", rr_a_ready, 1);
    step();
    chk("bubble_full", rr_a_ready, 0);
    chk("bubble_hold_hue", rr_hue, 120);
    a_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bubble_blue_valid", rr_out_valid, 1);
    chk("bubble_blue_hue", rr_hue, 240);
    step();
    chk("bubble_empty", rr_out_valid, 0);

    // counter saturation on the 4-bit build with white pixels
    do_reset();
    a_valid = 1'b1; a_rgb = 24'hFFFFFF;
    for (int k = 0; k < 20; k++) step();
    a_valid = 1'b0;
    chk("sat_c4_cnt_a", c4_cnt_a, 4'hF);
    chk("sat_rr_cnt_a", rr_cnt_a, 20);
    chk("sat_c4_valid", c4_out_valid, 1);
    chk("sat_c4_white_sat", c4_sat, 0);
    chk("sat_c4_white_lum", c4_lum, 18'h10000);
    step();
    step();
    chk("sat_c4_stuck", c4_cnt_a, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
